beacon_watchdog_cfg_arbiter: RTL and testbench

Round-robin arbiter/sequencer that shares the beacon watchdog's single AXI4-Lite register port (4 × 32-bit registers, offsets 0x0/0x4/0x8/0xC) among NUM_REQ local requesters. Each requester issues one single-beat read or write. The block serialises requests and drives AXI4-Lite master signals. It returns read data and response to the granted requester. It sits between on-chip configuration sources (CPU bridge, self-test, supervisor) and the watchdog slave.

---
 rtl/beacon_watchdog_cfg_arbiter_if.sv | 35 +++
 rtl/beacon_watchdog_cfg_arbiter.sv | 180 ++++++++++++++++++
 tb/tb_beacon_watchdog_cfg_arbiter.sv | 287 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/beacon_watchdog_cfg_arbiter_if.sv
// beacon_watchdog_cfg_arbiter_if: AXI4-Lite register-port signals between the arbiter (master) and the watchdog (slave).
interface beacon_watchdog_cfg_arbiter_if #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0]   awaddr;
    logic [2:0]              awprot;
    logic                    awvalid;
    logic                    awready;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wstrb;
    logic                    wvalid;
    logic                    wready;
    logic [1:0]              bresp;
    logic                    bvalid;
    logic                    bready;
    logic [ADDR_WIDTH-1:0]   araddr;
    logic [2:0]              arprot;
    logic                    arvalid;
    logic                    arready;
    logic [DATA_WIDTH-1:0]   rdata;
    logic [1:0]              rresp;
    logic                    rvalid;
    logic                    rready;

    modport master (
        output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready, araddr, arprot, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport slave (
        input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready, araddr, arprot, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/beacon_watchdog_cfg_arbiter.sv
// beacon_watchdog_cfg_arbiter: round-robin sequencer sharing the watchdog AXI4-Lite port among NUM_REQ requesters.
// Define BEACON_WDG_ARB_TIMEOUT_EN to add the response timeout, the TIMEOUT_CYCLES parameter and the timeout_flag port.
module beacon_watchdog_cfg_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 32
`ifdef BEACON_WDG_ARB_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES = 256
`endif
) (
    input  logic                          ACLK,
    input  logic                          ARESETN,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ-1:0]            req_we,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic [NUM_REQ-1:0]            rsp_valid,
    output logic [DATA_WIDTH-1:0]         rsp_rdata,
    output logic [1:0]                    rsp_resp,
`ifdef BEACON_WDG_ARB_TIMEOUT_EN
    output logic                          timeout_flag,
`endif
    beacon_watchdog_cfg_arbiter_if.master m_axi
);
    localparam int IW = $clog2(NUM_REQ);

    typedef enum logic [2:0] {IDLE, WR_ADDR_DATA, WR_RESP, RD_ADDR, RD_DATA, RESP} state_t;

    state_t                  state_q, state_d;
    logic [IW-1:0]           ptr_q, ptr_d, gnt_q, gnt_d, sel;
    logic                    found;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d, rdata_q, rdata_d;
    logic [1:0]              resp_q, resp_d;
    logic                    aw_done_q, aw_done_d, w_done_q, w_done_d;
    logic [NUM_REQ-1:0]      rdy_q, rdy_d;
    logic                    awv, wv, tmo;

    // First pending requester at or after the pointer, wrapping.
    always_comb begin
        found = 1'b0;
        sel   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!found && req_valid[(int'(ptr_q) + k) % NUM_REQ]) begin
                found = 1'b1;
                sel   = IW'((int'(ptr_q) + k) % NUM_REQ);
            end
        end
    end

    assign awv = state_q == WR_ADDR_DATA && !aw_done_q;
    assign wv  = state_q == WR_ADDR_DATA && !w_done_q;

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        gnt_d     = gnt_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        resp_d    = resp_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        rdy_d     = '0;
        case (state_q)
            IDLE: begin
                if (found) begin
                    gnt_d      = sel;
                    addr_d     = req_addr[int'(sel)*ADDR_WIDTH +: ADDR_WIDTH];
                    wdata_d    = req_wdata[int'(sel)*DATA_WIDTH +: DATA_WIDTH];
                    aw_done_d  = 1'b0;
                    w_done_d   = 1'b0;
                    rdy_d[sel] = 1'b1;
                    state_d    = req_we[sel] ? WR_ADDR_DATA : RD_ADDR;
                end
            end
            WR_ADDR_DATA: begin
                aw_done_d = aw_done_q | (awv & m_axi.awready);
                w_done_d  = w_done_q | (wv & m_axi.wready);
                state_d   = (aw_done_d && w_done_d) ? WR_RESP : WR_ADDR_DATA;
            end
            WR_RESP: begin
                if (m_axi.bvalid) begin
                    resp_d  = m_axi.bresp;
                    rdata_d = '0;
                    state_d = RESP;
                end
            end
            RD_ADDR: state_d = m_axi.arready ? RD_DATA : RD_ADDR;
            RD_DATA: begin
                if (m_axi.rvalid) begin
                    resp_d  = m_axi.rresp;
                    rdata_d = m_axi.rdata;
                    state_d = RESP;
                end
            end
            RESP: begin
                ptr_d   = IW'((int'(gnt_q) + 1) % NUM_REQ);
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (tmo) begin
            state_d = RESP;
            resp_d  = 2'b10;
            rdata_d = '0;
        end
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            gnt_q     <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            resp_q    <= '0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            rdy_q     <= '0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            gnt_q     <= gnt_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            rdata_q   <= rdata_d;
            resp_q    <= resp_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
            rdy_q     <= rdy_d;
        end
    end

`ifdef BEACON_WDG_ARB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [TW-1:0] cnt_q, cnt_d;
    logic          to_q;
    logic          busy;

    // Counter restarts on every state change, so it measures time spent in the current AXI phase.
    assign busy  = state_q inside {WR_ADDR_DATA, WR_RESP, RD_ADDR, RD_DATA};
    assign tmo   = busy && cnt_q == TW'(TIMEOUT_CYCLES - 1);
    assign cnt_d = (state_d != state_q) ? '0 : cnt_q + 1'b1;

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            cnt_q <= '0;
            to_q  <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            to_q  <= to_q | tmo;
        end
    end

    assign timeout_flag = to_q;
`else
    assign tmo = 1'b0;
`endif

    assign req_ready     = rdy_q;
    assign rsp_valid     = (state_q == RESP) ? (NUM_REQ'(1) << gnt_q) : '0;
    assign rsp_rdata     = (state_q == RESP) ? rdata_q : '0;
    assign rsp_resp      = (state_q == RESP) ? resp_q : '0;
    assign m_axi.awaddr  = addr_q;
    assign m_axi.awprot  = 3'b000;
    assign m_axi.awvalid = awv;
    assign m_axi.wdata   = wdata_q;
    assign m_axi.wstrb   = {(DATA_WIDTH/8){wv}};
    assign m_axi.wvalid  = wv;
    assign m_axi.bready  = state_q == WR_RESP;
    assign m_axi.araddr  = addr_q;
    assign m_axi.arprot  = 3'b000;
    assign m_axi.arvalid = state_q == RD_ADDR;
    assign m_axi.rready  = state_q == RD_DATA;
endmodule

// File: tb/tb_beacon_watchdog_cfg_arbiter.sv
// tb_beacon_watchdog_cfg_arbiter: directed bench with a 4-register AXI4-Lite slave model.
module tb_beacon_watchdog_cfg_arbiter;
    localparam int N = 4;

    logic ACLK = 1'b0, ARESETN = 1'b0;
    always #5 ACLK = ~ACLK;

    logic [N-1:0]    req_valid = '0, req_we = '0;
    logic [N*4-1:0]  req_addr = '0;
    logic [N*32-1:0] req_wdata = '0;
    logic [N-1:0]    req_ready, rsp_valid;
    logic [31:0]     rsp_rdata;
    logic [1:0]      rsp_resp;
`ifdef BEACON_WDG_ARB_TIMEOUT_EN
    logic            timeout_flag;
`endif

    beacon_watchdog_cfg_arbiter_if #(.ADDR_WIDTH(4), .DATA_WIDTH(32)) ax ();

    beacon_watchdog_cfg_arbiter #(
        .NUM_REQ(N), .ADDR_WIDTH(4), .DATA_WIDTH(32)
`ifdef BEACON_WDG_ARB_TIMEOUT_EN
        , .TIMEOUT_CYCLES(16)
`endif
    ) dut (
        .ACLK(ACLK), .ARESETN(ARESETN),
        .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
`ifdef BEACON_WDG_ARB_TIMEOUT_EN
        .timeout_flag(timeout_flag),
`endif
        .m_axi(ax)
    );

    // Slave model: awready delayed by aw_delay cycles, reads held off by r_hold, B suppressed by no_b.
    int          aw_delay = 0, aw_cnt;
    logic        r_hold = 1'b0, no_b = 1'b0;
    logic [31:0] mem [4];
    logic        aw_got, w_got, rd_pend;
    logic [3:0]  aw_a, rd_a, wa, ra;
    logic [31:0] w_d;
    logic        aw_hs, w_hs, ar_hs;

    assign ax.awready = aw_cnt >= aw_delay;
    assign ax.wready  = 1'b1;
    assign ax.arready = 1'b1;
    assign ax.bresp   = 2'b00;
    assign ax.rresp   = 2'b00;
    assign aw_hs = ax.awvalid && ax.awready;
    assign w_hs  = ax.wvalid && ax.wready;
    assign ar_hs = ax.arvalid && ax.arready;
    assign wa = aw_hs ? ax.awaddr : aw_a;
    assign ra = ar_hs ? ax.araddr : rd_a;

    always @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            aw_cnt <= 0; aw_got <= 1'b0; w_got <= 1'b0; rd_pend <= 1'b0;
            ax.bvalid <= 1'b0; ax.rvalid <= 1'b0; ax.rdata <= '0;
        end else begin
            aw_cnt <= (ax.awvalid && !ax.awready) ? aw_cnt + 1 : 0;
            if (ax.bvalid && ax.bready) ax.bvalid <= 1'b0;
            if (ax.rvalid && ax.rready) ax.rvalid <= 1'b0;
            if ((aw_got || aw_hs) && (w_got || w_hs)) begin
                mem[wa[3:2]] <= w_hs ? ax.wdata : w_d;
                aw_got <= 1'b0; w_got <= 1'b0;
                ax.bvalid <= !no_b;
            end else begin
                if (aw_hs) begin aw_got <= 1'b1; aw_a <= ax.awaddr; end
                if (w_hs) begin w_got <= 1'b1; w_d <= ax.wdata; end
            end
            if ((ar_hs || rd_pend) && !r_hold) begin
                ax.rvalid <= 1'b1; ax.rdata <= mem[ra[3:2]]; rd_pend <= 1'b0;
            end else if (ar_hs) begin
                rd_pend <= 1'b1; rd_a <= ax.araddr;
            end
        end
    end

    // Monitor: grant/response order and per-cycle AXI activity counts.
    int cyc = 0, aw_cyc = 0, w_cyc = 0, b_hs = 0, br_cyc = 0;
    int gq[$], gc[$], rq[$];
    always @(negedge ACLK) begin
        cyc++;
        for (int i = 0; i < N; i++) begin
            if (req_ready[i]) begin gq.push_back(i); gc.push_back(cyc); end
            if (rsp_valid[i]) rq.push_back(i);
        end
        aw_cyc += int'(ax.awvalid);
        w_cyc  += int'(ax.wvalid);
        br_cyc += int'(ax.bready);
        b_hs   += int'(ax.bvalid && ax.bready);
    end

    int compared = 0, mismatched = 0;

    task automatic set_req(input int i, input logic we, input logic [3:0] a, input logic [31:0] d);
        req_we[i] = we;
        req_addr[i*4 +: 4] = a;
        req_wdata[i*32 +: 32] = d;
        req_valid[i] = 1'b1;
    endtask

    task automatic do_txn(input int i, input logic we, input logic [3:0] a, input logic [31:0] d,
                          output logic [31:0] rd, output logic [1:0] rs, output int lat, output logic ok);
        @(negedge ACLK);
        set_req(i, we, a, d);
        lat = 1; ok = 1'b0; rd = '0; rs = '0;
        for (int k = 0; k < 60 && !ok; k++) begin
            @(negedge ACLK);
            lat++;
            if (req_ready[i]) req_valid[i] = 1'b0;
            if (rsp_valid[i]) begin ok = 1'b1; rd = rsp_rdata; rs = rsp_resp; end
        end
        req_valid[i] = 1'b0;
    endtask

    task automatic pulse_reset();
        @(negedge ACLK); ARESETN = 1'b0;
        @(negedge ACLK); ARESETN = 1'b1;
    endtask

    task automatic test_reset();
        req_valid = '1;
        repeat (3) @(negedge ACLK);
        compared += 8;
        if (req_ready !== 4'h0) begin mismatched++; $display("FAIL rst_req_ready: got %h want 0", req_ready); end
        if (rsp_valid !== 4'h0) begin mismatched++; $display("FAIL rst_rsp_valid: got %h want 0", rsp_valid); end
        if (rsp_rdata !== 32'h0) begin mismatched++; $display("FAIL rst_rsp_rdata: got %h want 0", rsp_rdata); end
        if (rsp_resp !== 2'b00) begin mismatched++; $display("FAIL rst_rsp_resp: got %h want 0", rsp_resp); end
        if ({ax.awvalid, ax.wvalid, ax.arvalid} !== 3'b000) begin mismatched++; $display("FAIL rst_valids: got %b want 000", {ax.awvalid, ax.wvalid, ax.arvalid}); end
        if ({ax.bready, ax.rready} !== 2'b00) begin mismatched++; $display("FAIL rst_readies: got %b want 00", {ax.bready, ax.rready}); end
        if (ax.wstrb !== 4'h0) begin mismatched++; $display("FAIL rst_wstrb: got %h want 0", ax.wstrb); end
        if ({ax.awprot, ax.arprot} !== 6'h0) begin mismatched++; $display("FAIL rst_prot: got %h want 0", {ax.awprot, ax.arprot}); end
        req_valid = '0;
        @(negedge ACLK); ARESETN = 1'b1;
    endtask

    task automatic test_single();
        logic [31:0] rd; logic [1:0] rs; int lat; logic ok;
        do_txn(0, 1'b1, 4'h0, 32'h1, rd, rs, lat, ok);
        compared += 4;
        if (ok !== 1'b1) begin mismatched++; $display("FAIL wr_done: got %b want 1", ok); end
        if (lat != 4) begin mismatched++; $display("FAIL wr_latency: got %0d want 4", lat); end
        if (rs !== 2'b00) begin mismatched++; $display("FAIL wr_resp: got %h want 0", rs); end
        if (rd !== 32'h0) begin mismatched++; $display("FAIL wr_rdata: got %h want 0", rd); end
        do_txn(0, 1'b0, 4'h0, 32'h0, rd, rs, lat, ok);
        compared += 4;
        if (ok !== 1'b1) begin mismatched++; $display("FAIL rd_done: got %b want 1", ok); end
        if (lat != 4) begin mismatched++; $display("FAIL rd_latency: got %0d want 4", lat); end
        if (rs !== 2'b00) begin mismatched++; $display("FAIL rd_resp: got %h want 0", rs); end
        if (rd !== 32'h1) begin mismatched++; $display("FAIL rd_rdata: got %h want 1", rd); end
    endtask

    task automatic test_back_to_back();
        int g0, r0; logic [31:0] rd; logic [1:0] rs; int lat; logic ok;
        pulse_reset();
        g0 = gq.size(); r0 = rq.size();
        @(negedge ACLK);
        for (int i = 0; i < N; i++) set_req(i, 1'b1, 4'(4*i), 32'(i+1));
        for (int k = 0; k < 80 && (rq.size() - r0) < 4; k++) begin
            @(negedge ACLK);
            for (int j = 0; j < N; j++) if (req_ready[j]) req_valid[j] = 1'b0;
        end
        req_valid = '0;
        compared++;
        if (rq.size() - r0 != 4) begin mismatched++; $display("FAIL b2b_rsp_count: got %0d want 4", rq.size() - r0); end
        for (int k = 0; k < 4; k++) begin
            compared += 2;
            if (gq[g0+k] != k) begin mismatched++; $display("FAIL b2b_grant%0d: got %0d want %0d", k, gq[g0+k], k); end
            if (rq[r0+k] != k) begin mismatched++; $display("FAIL b2b_rsp%0d: got %0d want %0d", k, rq[r0+k], k); end
        end
        compared++;
        if (gc[g0+1] - gc[g0] != 4) begin mismatched++; $display("FAIL b2b_grant_gap: got %0d want 4", gc[g0+1] - gc[g0]); end
        for (int k = 0; k < 4; k++) begin
            do_txn(k, 1'b0, 4'(4*k), 32'h0, rd, rs, lat, ok);
            compared++;
            if (rd !== 32'(k+1)) begin mismatched++; $display("FAIL readback%0d: got %h want %h", k, rd, 32'(k+1)); end
        end
    endtask

    task automatic test_aw_delay();
        int a0, w0, b0; logic [31:0] rd; logic [1:0] rs; int lat; logic ok;
        aw_delay = 3;
        a0 = aw_cyc; w0 = w_cyc; b0 = b_hs;
        do_txn(2, 1'b1, 4'h8, 32'hA5, rd, rs, lat, ok);
        aw_delay = 0;
        compared += 6;
        if (ok !== 1'b1 || rs !== 2'b00) begin mismatched++; $display("FAIL awd_rsp: got ok=%b resp=%h want ok=1 resp=0", ok, rs); end
        if (aw_cyc - a0 != 4) begin mismatched++; $display("FAIL awd_awvalid_cycles: got %0d want 4", aw_cyc - a0); end
        if (w_cyc - w0 != 1) begin mismatched++; $display("FAIL awd_wvalid_cycles: got %0d want 1", w_cyc - w0); end
        if (b_hs - b0 != 1) begin mismatched++; $display("FAIL awd_b_phases: got %0d want 1", b_hs - b0); end
        if (lat != 7) begin mismatched++; $display("FAIL awd_latency: got %0d want 7", lat); end
        if (mem[2] !== 32'hA5) begin mismatched++; $display("FAIL awd_slave_data: got %h want a5", mem[2]); end
    endtask

    task automatic test_no_starve();
        int g0, r0;
        pulse_reset();
        g0 = gq.size(); r0 = rq.size();
        @(negedge ACLK);
        set_req(1, 1'b0, 4'h4, 32'h0);
        set_req(2, 1'b0, 4'h8, 32'h0);
        for (int k = 0; k < 80 && (rq.size() - r0) < 3; k++) begin
            @(negedge ACLK);
            if (req_ready[2]) req_valid[2] = 1'b0;
            if (gq.size() - g0 >= 3) req_valid[1] = 1'b0;
        end
        req_valid = '0;
        compared += 4;
        if (rq.size() - r0 != 3) begin mismatched++; $display("FAIL starve_rsp_count: got %0d want 3", rq.size() - r0); end
        if (gq[g0] != 1) begin mismatched++; $display("FAIL starve_grant0: got %0d want 1", gq[g0]); end
        if (gq[g0+1] != 2) begin mismatched++; $display("FAIL starve_grant1: got %0d want 2", gq[g0+1]); end
        if (gq[g0+2] != 1) begin mismatched++; $display("FAIL starve_grant2: got %0d want 1", gq[g0+2]); end
    endtask

    task automatic test_reset_mid();
        int g0, r0;
        r_hold = 1'b1;
        @(negedge ACLK);
        set_req(3, 1'b0, 4'hC, 32'h0);
        for (int k = 0; k < 10 && !ax.rready; k++) begin
            @(negedge ACLK);
            if (req_ready[3]) req_valid[3] = 1'b0;
        end
        req_valid = '0;
        compared++;
        if (ax.rready !== 1'b1) begin mismatched++; $display("FAIL mid_reach_rd_data: got %b want 1", ax.rready); end
        r0 = rq.size();
        ARESETN = 1'b0;
        #1;
        compared += 3;
        if (ax.rready !== 1'b0) begin mismatched++; $display("FAIL mid_rready: got %b want 0", ax.rready); end
        if (rsp_valid !== 4'h0 || req_ready !== 4'h0) begin mismatched++; $display("FAIL mid_req_rsp: got %h/%h want 0/0", rsp_valid, req_ready); end
        if ({ax.awvalid, ax.wvalid, ax.arvalid, ax.bready} !== 4'h0) begin mismatched++; $display("FAIL mid_axi: got %b want 0000", {ax.awvalid, ax.wvalid, ax.arvalid, ax.bready}); end
        repeat (2) @(negedge ACLK);
        ARESETN = 1'b1; r_hold = 1'b0;
        repeat (3) @(negedge ACLK);
        compared++;
        if (rq.size() != r0) begin mismatched++; $display("FAIL mid_no_rsp: got %0d want 0", rq.size() - r0); end
        g0 = gq.size(); r0 = rq.size();
        set_req(3, 1'b0, 4'hC, 32'h0);
        set_req(0, 1'b0, 4'h0, 32'h0);
        for (int k = 0; k < 60 && (rq.size() - r0) < 2; k++) begin
            @(negedge ACLK);
            for (int j = 0; j < N; j++) if (req_ready[j]) req_valid[j] = 1'b0;
        end
        req_valid = '0;
        compared += 3;
        if (rq.size() - r0 != 2) begin mismatched++; $display("FAIL mid_after_count: got %0d want 2", rq.size() - r0); end
        if (gq[g0] != 0) begin mismatched++; $display("FAIL mid_after_grant0: got %0d want 0", gq[g0]); end
        if (gq[g0+1] != 3) begin mismatched++; $display("FAIL mid_after_grant1: got %0d want 3", gq[g0+1]); end
    endtask

`ifdef BEACON_WDG_ARB_TIMEOUT_EN
    task automatic test_timeout();
        int br0; logic [31:0] rd; logic [1:0] rs; int lat; logic ok;
        pulse_reset();
        compared++;
        if (timeout_flag !== 1'b0) begin mismatched++; $display("FAIL to_flag_init: got %b want 0", timeout_flag); end
        no_b = 1'b1;
        br0 = br_cyc;
        do_txn(0, 1'b1, 4'h0, 32'h7, rd, rs, lat, ok);
        no_b = 1'b0;
        compared += 5;
        if (ok !== 1'b1 || rs !== 2'b10) begin mismatched++; $display("FAIL to_resp: got ok=%b resp=%h want ok=1 resp=2", ok, rs); end
        if (rd !== 32'h0) begin mismatched++; $display("FAIL to_rdata: got %h want 0", rd); end
        if (br_cyc - br0 != 16) begin mismatched++; $display("FAIL to_wr_resp_cycles: got %0d want 16", br_cyc - br0); end
        if (lat != 19) begin mismatched++; $display("FAIL to_latency: got %0d want 19", lat); end
        @(negedge ACLK);
        if (timeout_flag !== 1'b1) begin mismatched++; $display("FAIL to_flag_sticky: got %b want 1", timeout_flag); end
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_aw_delay();
        test_no_starve();
        test_reset_mid();
`ifdef BEACON_WDG_ARB_TIMEOUT_EN
        test_timeout();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
